// File: rtl/matrix_capture.sv
// Captures an LED-matrix scan (row/column shift registers plus latch) into a 16x16 frame buffer.
// Optional macro MATRIX_CAPTURE_ERRCNT_EN enables the rejected-latch counter on err_count.
module matrix_capture #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rclk,
  input  logic        rsdi,
  input  logic        cclk,
  input  logic        csdi,
  input  logic        le,
  input  logic        oeb,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_data,
  output logic        frame_done,
  output logic [7:0]  le_count,
  output logic [7:0]  err_count,
  output logic        lit
);

  localparam int unsigned NPIN = 6;
  localparam int unsigned P_RCLK = 0, P_RSDI = 1, P_CCLK = 2, P_CSDI = 3, P_LE = 4, P_OEB = 5;

  logic [NPIN-1:0]        pins;
  logic [SYNC_STAGES-1:0] sy [NPIN];
  logic [NPIN-1:0]        s;
  logic [2:0]             prv;
  logic                   rclk_rise, cclk_rise, le_rise;

  logic [15:0] row_sr, col_sr, row_lat, col_lat;
  logic [15:0] fb [16];
  logic        wr_pend;
  logic        lat_ok;
  logic [3:0]  lat_idx;

  assign pins = {oeb, le, csdi, cclk, rsdi, rclk};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NPIN; i++) sy[i] <= '0;
      prv <= '0;
    end else begin
      for (int i = 0; i < NPIN; i++) sy[i] <= {sy[i][SYNC_STAGES-2:0], pins[i]};
      prv <= {s[P_LE], s[P_CCLK], s[P_RCLK]};
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < NPIN; i++) s[i] = sy[i][SYNC_STAGES-1];
  end

  assign rclk_rise = s[P_RCLK] & ~prv[0];
  assign cclk_rise = s[P_CCLK] & ~prv[1];
  assign le_rise   = s[P_LE]   & ~prv[2];

  // Row must be exactly one-hot to address a frame-buffer row.
  always_comb begin
    lat_ok  = (row_lat != 16'h0000) && ((row_lat & (row_lat - 16'd1)) == 16'h0000);
    lat_idx = '0;
    for (int i = 0; i < 16; i++)
      if (row_lat[i]) lat_idx = i[3:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_sr     <= '0;
      col_sr     <= '0;
      row_lat    <= '0;
      col_lat    <= '0;
      le_count   <= '0;
      wr_pend    <= 1'b0;
      frame_done <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < 16; i++) fb[i] <= '0;
    end else begin
      // Latch takes the pre-shift value when a shift edge lands in the same cycle.
      if (rclk_rise) row_sr <= {row_sr[14:0], s[P_RSDI]};
      if (cclk_rise) col_sr <= {col_sr[14:0], s[P_CSDI]};
      if (le_rise) begin
        row_lat  <= row_sr;
        col_lat  <= col_sr;
        le_count <= le_count + 8'd1;
      end
      wr_pend    <= le_rise;
      frame_done <= 1'b0;
      if (wr_pend && lat_ok) begin
        fb[lat_idx] <= ~col_lat;
        frame_done  <= (lat_idx == 4'd15);
      end
      rd_data <= fb[rd_row];
    end
  end

`ifdef MATRIX_CAPTURE_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= '0;
    else if (wr_pend && !lat_ok && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign lit = ~s[P_OEB] & lat_ok;

endmodule
